// File: rtl/kbd_scan_fifo.sv
// PS/2 keyboard receiver feeding a scancode FIFO popped by an I/O-bus acknowledge.
// Optional odd-parity rejection is enabled by defining KBD_PARITY_CHECK_EN.
module kbd_scan_fifo #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       intAck,
  output logic [7:0] code,
  output logic       int_req,
  output logic       overflow,
  output logic       perr,
  output logic [1:0] state_dbg
);
  // Handshake: the bus raises intAck (level, >=1 cycle) to consume the entry shown
  // on code; only its 0->1 transition pops, and int_req stays high while data is queued.

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

  state_t           state;
  logic             clk_s1, clk_s2, clk_s3;
  logic             dat_s1, dat_s2;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [TW-1:0]    to_cnt;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0]       last_code;
  logic             ack_d;

  logic fall, empty, full, frame_ok, push, pop;

  assign fall  = clk_s3 & ~clk_s2;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // shreg holds {stop, parity, data[7:0]} once all ten post-start bits are in
`ifdef KBD_PARITY_CHECK_EN
  assign frame_ok = shreg[9] & (^shreg[8:0]);
`else
  assign frame_ok = shreg[9];
`endif

  assign push = (state == CHECK) && frame_ok;
  assign pop  = intAck && !ack_d && !empty;

  assign code      = empty ? last_code : mem[rd_ptr[FIFO_AW-1:0]];
  assign int_req   = !empty;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_s3    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      bit_cnt   <= 4'd0;
      shreg     <= 10'd0;
      to_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_code <= 8'h00;
      ack_d     <= 1'b0;
      overflow  <= 1'b0;
      perr      <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      ack_d  <= intAck;
      perr   <= 1'b0;

      if (fall)
        to_cnt <= '0;
      else if (to_cnt != TO_LIM)
        to_cnt <= to_cnt + TW'(1);

      case (state)
        IDLE: begin
          bit_cnt <= 4'd0;
          if (fall && !dat_s2)
            state <= SHIFT;
        end
        SHIFT: begin
          if (fall) begin
            shreg <= {dat_s2, shreg[9:1]};
            if (bit_cnt == 4'd9)
              state <= CHECK;
            else
              bit_cnt <= bit_cnt + 4'd1;
          end else if (to_cnt == TO_LIM) begin
            // stalled partial frame: drop it silently
            state <= IDLE;
          end
        end
        CHECK: begin
          perr  <= !frame_ok;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      if (push && (!full || pop))
        wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
      else if (push)
        overflow <= 1'b1;

      if (pop) begin
        rd_ptr    <= rd_ptr + (FIFO_AW+1)'(1);
        last_code <= mem[rd_ptr[FIFO_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && (!full || pop))
      mem[wr_ptr[FIFO_AW-1:0]] <= shreg[7:0];
  end

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Bench for kbd_scan_fifo: table of single frames, hand sequences for FIFO/reset/timeout
// corners, then random frames and acks against a queue-based reference model.
module tb_kbd_scan_fifo;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 2000;
  localparam int HALF  = 10;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       intAck = 1'b0;
  logic [7:0] code;
  logic       int_req, overflow, perr;
  logic [1:0] state_dbg;

  kbd_scan_fifo #(.FIFO_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .intAck(intAck),
    .code(code), .int_req(int_req), .overflow(overflow), .perr(perr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int perr_cnt = 0;
  logic       cap_int;
  logic [7:0] cap_code;

  // reference model
  logic [7:0] exp_q[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf  = 1'b0;

  always @(negedge clk) if (perr === 1'b1) perr_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ok_rule(input logic [7:0] d, input logic p, input logic s);
    return s && (!PAR_EN || ($countones({d, p}) % 2 == 1));
  endfunction

  function automatic logic [7:0] m_code();
    return (exp_q.size() != 0) ? exp_q[0] : m_last;
  endfunction

  task automatic m_pop();
    if (exp_q.size() != 0) m_last = exp_q.pop_front();
  endtask

  task automatic check_model(input string name);
    chk({name, "_int"}, int_req, exp_q.size() != 0);
    chk({name, "_code"}, code, m_code());
    chk({name, "_ovf"}, overflow, m_ovf);
  endtask

  // drive bits LSB first; ps2_clk falls mid-bit, capture outputs 4 cycles after the last fall
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit ack_at_push);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == nbits - 1) begin
        repeat (3) @(posedge clk);
        if (ack_at_push) #1 intAck = 1'b1;
        @(posedge clk); #1;
        cap_int  = int_req;
        cap_code = code;
        repeat (HALF - 4) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input bit ack_at_push);
    send_bits({s, p, d, 1'b0}, 11, ack_at_push);
    if (ack_at_push) m_pop();
    if (ok_rule(d, p, s)) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_ack(input int hold);
    @(posedge clk); #1 intAck = 1'b1;
    repeat (hold) @(posedge clk);
    #1 intAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_pop();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       exp_int;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int p0;
    logic [7:0] d;
    logic p, s;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, !PAR_EN, 8'h1C};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80};
    vecs[8] = '{8'h80, 1'b1, 1'b1, !PAR_EN, 8'h80};

    repeat (4) @(posedge clk);
    #1;
    chk("rst_int", int_req, 1'b0);
    chk("rst_code", code, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_perr", perr, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // single frames from an empty FIFO, each acknowledged afterwards
    foreach (vecs[i]) begin
      p0 = perr_cnt;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s, 1'b0);
      chk($sformatf("vec%0d_int4", i), cap_int, vecs[i].exp_int);
      chk($sformatf("vec%0d_code4", i), cap_code, vecs[i].exp_code);
      chk($sformatf("vec%0d_perr", i), perr_cnt - p0, !vecs[i].exp_int);
      do_ack(1);
      check_model($sformatf("vec%0d_acked", i));
    end

    // two frames, long ack pops exactly one
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("two_code", code, 8'hF0);
    do_ack(10);
    chk("two_code_a1", code, 8'h1C);
    chk("two_int_a1", int_req, 1'b1);
    do_ack(1);
    chk("two_int_a2", int_req, 1'b0);
    check_model("two_end");

    // nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, ~^d, 1'b1, 1'b0);
    end
    chk("ovf_set", overflow, 1'b1);
    check_model("ovf_full");
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), code, 8'(i));
      do_ack(1 + (i % 3));
    end
    check_model("ovf_drained");

    // reset mid-frame with data queued and overflow set
    for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), ~^(8'h30 + 8'(i)), 1'b1, 1'b0);
    check_model("pre_rst");
    send_bits(11'b000_0110_1010, 5, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_int", int_req, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_code", code, 8'h00);
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_last = 8'h00;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("post_rst_code", code, 8'h5A);
    check_model("post_rst");
    do_ack(1);

    // push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ~^d, 1'b1, 1'b0);
    end
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    #1 intAck = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("pp_cnt", exp_q.size(), DEPTH);
    check_model("pp_full");
    for (int i = 0; i < DEPTH; i++) do_ack(1);
    check_model("pp_drained");
    chk("pp_last", code, 8'hC3);

    // abandoned partial frame followed by a long idle
    p0 = perr_cnt;
    send_bits(11'b000_0001_0110, 5, 1'b0);
    repeat (TO + 500) @(posedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    chk("to_code", code, 8'h29);
    chk("to_int", int_req, 1'b1);
    chk("to_perr", perr_cnt - p0, 0);
    do_ack(1);
    check_model("to_end");

    // random traffic
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      p = ~^d ^ ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 9) != 0);
      p0 = perr_cnt;
      send_frame(d, p, s, 1'b0);
      chk($sformatf("rnd%0d_perr", i), perr_cnt - p0, !ok_rule(d, p, s));
      check_model($sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin
        do_ack($urandom_range(1, 5));
        check_model($sformatf("rnd%0d_ack", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_scan_fifo.md
KBD_SCAN_FIFO -- requirements
Module: kbd_scan_fifo

Interface
REQ-001 Parameter FIFO_AW, default 3, FIFO address width; depth = 2^FIFO_AW entries.
REQ-002 Parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock, 50 MHz nominal; sole clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data pin, asynchronous.
REQ-007 intAck  input  1  read acknowledge from the I/O bus, level, any length ≥1 cycle.
REQ-008 code  output  8  scancode at FIFO head.
REQ-009 int  output  1  high while FIFO non-empty.
REQ-010 overflow  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-011 perr  output  1  one-cycle pulse per rejected frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from a third registered copy of ps2_clk.
REQ-013 Receiver FSM states: IDLE, SHIFT, CHECK. IDLE->SHIFT on a falling edge with synchronized data=0 (start bit); a falling edge with data=1 in IDLE SHALL be ignored.
REQ-014 SHIFT SHALL sample data on each falling edge: 8 data bits LSB first, then parity, then stop; a 4-bit counter SHALL track position; after the stop bit -> CHECK.
REQ-015 CHECK (one cycle) SHALL accept the frame if stop=1 (plus the parity rule of REQ-025), then return to IDLE.
REQ-016 Rejected frame: no push, perr=1 for that cycle, return to IDLE.
REQ-017 A timeout counter SHALL reset on each falling edge; in SHIFT, reaching TIMEOUT_CYC SHALL return to IDLE, discard partial data, no perr.
REQ-018 An accepted byte SHALL be written into the FIFO; int and code SHALL reflect it no later than 4 clk cycles after the stop-bit falling edge at the pin.
REQ-019 Pop SHALL occur on the rising edge of intAck (registered previous value 0, current 1); holding intAck high pops exactly one entry; a pop while empty SHALL be ignored.
REQ-020 code SHALL equal the head entry combinationally from the FIFO state; when empty code SHALL hold its last value (0x00 after reset).
REQ-021 Push while full and no pop the same cycle: byte dropped, overflow set to 1 and held until rst.
REQ-022 Push and pop in the same cycle SHALL both take effect; when full this SHALL NOT set overflow and occupancy is unchanged.
REQ-023 Read/write pointers SHALL be FIFO_AW+1 bits, wrapping modulo 2^(FIFO_AW+1); full = MSBs differ and low bits equal.

Reset
REQ-024 rst SHALL, regardless of mid-frame or FIFO state: FSM->IDLE, bit counter, timeout counter and pointers->0, synchronizers->1, intAck history->0; outputs code=0x00, int=0, overflow=0, perr=0.

Configuration
REQ-025 Macro KBD_PARITY_CHECK_EN: defined -> CHECK additionally requires odd parity over the 8 data bits plus parity bit, failing frames rejected per REQ-016; undefined -> parity bit sampled but ignored, only stop bit checked.

Verification
REQ-026 Frame 0x1C, parity 0, stop 1 -> int=1 within 4 cycles of the last falling edge, code=0x1C; intAck pulse -> int=0.
REQ-027 Frames 0xF0 then 0x1C, no ack -> code=0xF0; ack held 10 cycles -> code=0x1C, int=1; second ack -> int=0.
REQ-028 Nine frames 0x01..0x09, FIFO_AW=3, no ack -> overflow=1 after the ninth; eight acks return 0x01..0x08 in order; 0x09 never appears.
REQ-029 Frame 0x1C with parity 1 -> with KBD_PARITY_CHECK_EN: perr pulse, int stays 0; without: code=0x1C, int=1, perr stays 0.
REQ-030 Five bits of a frame, idle 1.2 ms, then a full 0x29 frame -> code=0x29, int=1, perr never asserted.
REQ-031 rst asserted mid-frame with 3 bytes queued and overflow=1 -> next cycle int=0, overflow=0, code=0x00; a subsequent 0x5A frame is received correctly.
